// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receiver and its receive-side FIFO.
package uart_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;

    typedef logic [DEFAULT_WORD_WIDTH-1:0] uart_word_t;

    typedef struct packed {
        logic       error;
        uart_word_t data;
    } rx_entry_t;

    // Statistics counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock circular FIFO with wrap-bit pointers and first-word-fall-through read.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: one capture per frame, drop/suppress policy
// and overflow/parity statistics around a sync_fifo.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter int DEPTH         = 16,
    parameter bit DROP_ON_ERROR = 1'b0
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [WORD_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_error,
    output logic [WORD_WIDTH-1:0]   m_data,
    output logic                    m_error,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    output logic [7:0]              err_count,
    input  logic                    clear_stats
);

    logic                  valid_q;
    logic                  cap;
    logic                  push;
    logic                  drop;
    logic                  full;
    logic                  empty;
    logic [WORD_WIDTH:0]   rd_entry;

    // valid_q resets high so a level already asserted at reset release is not a new frame.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) valid_q <= 1'b1;
        else        valid_q <= rx_valid;
    end

    assign cap  = rx_valid & ~valid_q;
    assign push = cap & ~(DROP_ON_ERROR & rx_error);
    assign drop = push & full & ~m_ready;

    sync_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (m_ready),
        .wr_data ({rx_error, rx_data}),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign m_valid = ~empty;
    assign m_error = rd_entry[WORD_WIDTH];
    assign m_data  = rd_entry[WORD_WIDTH-1:0];

    // Clear takes priority over any increment landing on the same edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            err_count  <= '0;
        end else if (clear_stats) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
            if (cap && rx_error) err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: a frame table plus hand-written corner sequences.
module tb_uart_rx_fifo;

    logic       clock = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       m_ready;
    logic       clear_stats;

    logic [7:0] m_data, m_data2;
    logic       m_error, m_error2;
    logic       m_valid, m_valid2;
    logic [4:0] level, level2;
    logic       overflow, overflow2;
    logic [7:0] drop_count, drop_count2;
    logic [7:0] err_count, err_count2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_rx_fifo #(.WORD_WIDTH(8), .DEPTH(16), .DROP_ON_ERROR(1'b0)) dut (
        .clock(clock), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .m_data(m_data), .m_error(m_error), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .overflow(overflow), .drop_count(drop_count),
        .err_count(err_count), .clear_stats(clear_stats)
    );

    uart_rx_fifo #(.WORD_WIDTH(8), .DEPTH(16), .DROP_ON_ERROR(1'b1)) dut_drop (
        .clock(clock), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .m_data(m_data2), .m_error(m_error2), .m_valid(m_valid2),
        .m_ready(m_ready), .level(level2), .overflow(overflow2), .drop_count(drop_count2),
        .err_count(err_count2), .clear_stats(clear_stats)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         hold;
        logic [7:0] exp_m_data;
        logic       exp_m_error;
        logic [7:0] exp_err_count;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic err, input int hold);
        rx_data  = data;
        rx_error = err;
        rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        rx_error = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_error = 1'b0;
        m_ready = 1'b0; clear_stats = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 868, 8'hA5, 1'b0, 8'd0};
        vecs[1] = '{8'h3C, 1'b1, 4,   8'h3C, 1'b1, 8'd1};
        vecs[2] = '{8'hFF, 1'b1, 1,   8'hFF, 1'b1, 8'd2};
        vecs[3] = '{8'h00, 1'b0, 10,  8'h00, 1'b0, 8'd2};

        #3;
        check_output("reset_level", level, 0);
        check_output("reset_m_valid", m_valid, 0);
        check_output("reset_overflow", overflow, 0);
        check_output("reset_drop_count", drop_count, 0);
        check_output("reset_err_count", err_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table: one frame into an empty FIFO, check 1-cycle latency, hold, then pop it.
        for (int i = 0; i < 4; i++) begin
            rx_data  = vecs[i].data;
            rx_error = vecs[i].err;
            rx_valid = 1'b1;
            tick();
            check_output($sformatf("vec%0d_m_valid", i), m_valid, 1);
            check_output($sformatf("vec%0d_level", i), level, 1);
            check_output($sformatf("vec%0d_m_data", i), m_data, vecs[i].exp_m_data);
            check_output($sformatf("vec%0d_m_error", i), m_error, vecs[i].exp_m_error);
            repeat (vecs[i].hold - 1) tick();
            rx_valid = 1'b0;
            rx_error = 1'b0;
            tick();
            check_output($sformatf("vec%0d_level_after_hold", i), level, 1);
            check_output($sformatf("vec%0d_err_count", i), err_count, vecs[i].exp_err_count);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            check_output($sformatf("vec%0d_popped", i), m_valid, 0);
        end

        // Three words, then continuous pops on consecutive cycles.
        apply_reset();
        apply_stimulus(8'h01, 1'b0, 2);
        apply_stimulus(8'h02, 1'b0, 2);
        apply_stimulus(8'h03, 1'b0, 2);
        check_output("seq_level3", level, 3);
        m_ready = 1'b1;
        check_output("seq_head0", m_data, 8'h01);
        tick();
        check_output("seq_head1", m_data, 8'h02);
        check_output("seq_level2", level, 2);
        tick();
        check_output("seq_head2", m_data, 8'h03);
        check_output("seq_level1", level, 1);
        tick();
        check_output("seq_level0", level, 0);
        check_output("seq_m_valid0", m_valid, 0);
        tick();
        check_output("seq_ready_when_empty", level, 0);
        m_ready = 1'b0;

        // Overflow: 18 words into 16 entries.
        apply_reset();
        for (int i = 0; i < 18; i++) apply_stimulus(8'h40 + 8'(i), 1'b0, 2);
        check_output("ovf_level", level, 16);
        check_output("ovf_flag", overflow, 1);
        check_output("ovf_drop_count", drop_count, 2);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check_output("clr_overflow", overflow, 0);
        check_output("clr_drop_count", drop_count, 0);
        check_output("clr_level", level, 16);

        // Full FIFO: capture coincides with a pop.
        rx_data = 8'h99; rx_valid = 1'b1; m_ready = 1'b1;
        tick();
        rx_valid = 1'b0; m_ready = 1'b0;
        check_output("fullpop_level", level, 16);
        check_output("fullpop_drop_count", drop_count, 0);
        check_output("fullpop_overflow", overflow, 0);
        m_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check_output($sformatf("drain_%0d", i), m_data, 8'h40 + 8'(i));
            tick();
        end
        check_output("drain_last", m_data, 8'h99);
        tick();
        check_output("drain_empty", m_valid, 0);
        m_ready = 1'b0;

        // Clear coinciding with an err_count increment.
        apply_reset();
        rx_data = 8'h5E; rx_error = 1'b1; rx_valid = 1'b1; clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
        check_output("clr_wins_err_count", err_count, 0);
        check_output("clr_keeps_fifo", level, 1);

        // Suppression of parity-error words in the DROP_ON_ERROR instance.
        apply_reset();
        apply_stimulus(8'h11, 1'b0, 3);
        apply_stimulus(8'h22, 1'b1, 3);
        apply_stimulus(8'h33, 1'b0, 3);
        check_output("drop_level", level2, 2);
        check_output("drop_err_count", err_count2, 1);
        check_output("drop_head0", m_data2, 8'h11);
        check_output("keep_level", level, 3);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_output("drop_head1", m_data2, 8'h33);
        check_output("drop_m_error", m_error2, 0);

        // Reset mid-operation with rx_valid still high at release.
        apply_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(8'h60 + 8'(i), 1'b0, 2);
        check_output("rst_pre_level", level, 5);
        rx_data = 8'h77; rx_valid = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_async_level", level, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_output("rst_release_level", level, 0);
        check_output("rst_release_m_valid", m_valid, 0);
        rx_valid = 1'b0;
        tick();
        rx_data = 8'h5A; rx_valid = 1'b1;
        tick();
        check_output("rst_next_edge_level", level, 1);
        check_output("rst_next_edge_data", m_data, 8'h5A);
        rx_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
